// File: rtl/cpu1_ram_arbiter_pkg.sv
// cpu1_ram_arbiter_pkg: shared types and constants for the CPU1 RAM arbiter.
// Rev 1.0
`default_nettype none

package cpu1_ram_arbiter_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_idx_t;

  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int DEFAULT_DEPTH = 1023;

endpackage

`default_nettype wire

// File: rtl/cpu1_ram_arbiter_rr_arb2.sv
// cpu1_ram_arbiter_rr_arb2: two-requester round-robin grant with last-grant memory.
// Rev 1.0
`default_nettype none

module cpu1_ram_arbiter_rr_arb2
  import cpu1_ram_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_i,
  output logic [1:0]  grant_o,
  output master_idx_t winner_o
);

  master_idx_t last_q;
  master_idx_t last_d;

  always_comb begin
    grant_o  = 2'b00;
    winner_o = M0;
    last_d   = last_q;
    case (req_i)
      2'b01: begin
        grant_o  = 2'b01;
        winner_o = M0;
      end
      2'b10: begin
        grant_o  = 2'b10;
        winner_o = M1;
      end
      2'b11: begin
        // On conflict the master that did not win last time takes the slot.
        if (last_q == M1) begin
          grant_o  = 2'b01;
          winner_o = M0;
        end else begin
          grant_o  = 2'b10;
          winner_o = M1;
        end
      end
      default: ;
    endcase
    if (|req_i) begin
      last_d = winner_o;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu1_ram_arbiter.sv
// cpu1_ram_arbiter: shares the single-port on-chip RAM between the CPU and alarm logger.
// Rev 1.0
`default_nettype none

module cpu1_ram_arbiter
  import cpu1_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [CNT_W-1:0]  contention_cnt,
  input  logic              contention_clr
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        req;
  logic [1:0]        grant;
  master_idx_t       winner;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wd;
  logic              sel_wr;
  logic              sel_rd;
  logic              accepted;
  logic              in_range;
  logic              rd_accept;
  logic [DATA_W-1:0] ret_data;

  logic              rd_pend_q, rd_pend_d;
  master_idx_t       rd_owner_q, rd_owner_d;
  logic              rd_oob_q, rd_oob_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Requests are masked while in reset so every output sits at its idle value.
  assign req = {(m1_read | m1_write) & reset_n, (m0_read | m0_write) & reset_n};

  cpu1_ram_arbiter_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req),
    .grant_o  (grant),
    .winner_o (winner)
  );

  always_comb begin
    sel_addr = '0;
    sel_be   = '0;
    sel_wd   = '0;
    sel_wr   = 1'b0;
    sel_rd   = 1'b0;
    if (grant[0]) begin
      sel_addr = m0_address;
      sel_be   = m0_byteenable;
      sel_wd   = m0_writedata;
      sel_wr   = m0_write;
      sel_rd   = m0_read;
    end else if (grant[1]) begin
      sel_addr = m1_address;
      sel_be   = m1_byteenable;
      sel_wd   = m1_writedata;
      sel_wr   = m1_write;
      sel_rd   = m1_read;
    end
  end

  assign accepted  = |grant;
  assign in_range  = ({1'b0, sel_addr} < DEPTH_L);
  assign rd_accept = accepted & sel_rd & ~sel_wr;

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  assign ram_address    = sel_addr;
  assign ram_byteenable = sel_be;
  assign ram_writedata  = sel_wd;
  assign ram_write      = sel_wr;
  assign ram_chipselect = accepted & in_range;
  assign ram_clken      = reset_n;

  always_comb begin
    rd_pend_d  = rd_accept;
    rd_owner_d = winner;
    rd_oob_d   = ~in_range;
    cnt_d      = cnt_q;
    if (contention_clr) begin
      cnt_d = '0;
    end else if ((&req) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M0;
      rd_oob_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oob_q   <= rd_oob_d;
      cnt_q      <= cnt_d;
    end
  end

  // Out-of-range reads never strobed the RAM, so its output is stale and is replaced by zero.
  assign ret_data         = rd_oob_q ? '0 : ram_readdata;
  assign m0_readdatavalid = rd_pend_q & (rd_owner_q == M0);
  assign m1_readdatavalid = rd_pend_q & (rd_owner_q == M1);
  assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : '0;
  assign contention_cnt   = cnt_q;

endmodule

`default_nettype wire
